// File: rtl/lane_unstriper4.sv
// Un-stripes one 4-lane word per transfer onto a single byte stream, lane0 first; 1 clk from capture to first byte.
// Holds out_data/ptr while out_ready=0; in_ready rises only when empty or while the last byte is leaving.
// Optional LANE_REVERSE_EN adds lane_rev (sampled at capture) to serialise lane3 first.
module lane_unstriper4 #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in0,
   input  logic [DATA_WIDTH-1:0] in1,
   input  logic [DATA_WIDTH-1:0] in2,
   input  logic [DATA_WIDTH-1:0] in3,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
`ifdef LANE_REVERSE_EN
   ,
   input  logic                  lane_rev
`endif
);

   typedef enum logic {EMPTY = 1'b0, SEND = 1'b1} state_t;

   state_t                state;
   logic [1:0]            ptr;
   logic [1:0]            ptr_nxt;
   logic [DATA_WIDTH-1:0] lane_buf [4];
   logic [DATA_WIDTH-1:0] word     [4];
   logic                  capture;
   logic                  advance;

   // Lane order is resolved at capture, so the buffer always drains 0..3.
   always_comb begin
      word[0] = in0;
      word[1] = in1;
      word[2] = in2;
      word[3] = in3;
`ifdef LANE_REVERSE_EN
      if (lane_rev) begin
         word[0] = in3;
         word[1] = in2;
         word[2] = in1;
         word[3] = in0;
      end
`endif
   end

   assign in_ready = (state == EMPTY) || ((ptr == 2'd3) && out_ready);
   assign capture  = in_valid && in_ready;
   assign advance  = (state == SEND) && out_ready;
   assign ptr_nxt  = ptr + 2'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= EMPTY;
         ptr       <= 2'd0;
         out_valid <= 1'b0;
         out_data  <= '0;
         for (int i = 0; i < 4; i++) lane_buf[i] <= '0;
      end else if (capture) begin
         state     <= SEND;
         ptr       <= 2'd0;
         out_valid <= 1'b1;
         out_data  <= word[0];
         for (int i = 0; i < 4; i++) lane_buf[i] <= word[i];
      end else if (advance) begin
         if (ptr == 2'd3) begin
            state     <= EMPTY;
            ptr       <= 2'd0;
            out_valid <= 1'b0;
         end else begin
            ptr      <= ptr_nxt;
            out_data <= lane_buf[ptr_nxt];
         end
      end
   end

endmodule

// File: tb/tb_lane_unstriper4.sv
// Bench for lane_unstriper4: directed scenarios plus randomized traffic against a byte-queue model.
module tb_lane_unstriper4;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready = 1'b0;
`ifdef LANE_REVERSE_EN
   logic         lane_rev = 1'b0;
`endif

   lane_unstriper4 #(.DATA_WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .in0      (in0),
      .in1      (in1),
      .in2      (in2),
      .in3      (in3),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready)
`ifdef LANE_REVERSE_EN
      ,
      .lane_rev (lane_rev)
`endif
   );

   always #5 clk = ~clk;

   logic [W-1:0] q[$];
   int           n_cmp = 0;
   int           n_err = 0;
   bit           acc;
   int           acc_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs against the queue model at negedge, then cross posedge.
   task automatic tick();
      bit exp_rdy;
      bit rev;
      @(negedge clk);
      exp_rdy = (q.size() == 0) || ((q.size() == 1) && out_ready);
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      if (q.size() != 0) begin
         chk("out_data", {24'd0, out_data}, {24'd0, q[0]});
         if (out_ready) void'(q.pop_front());
      end
      acc = in_valid && exp_rdy;
      if (acc) begin
         acc_cnt++;
         rev = 1'b0;
`ifdef LANE_REVERSE_EN
         rev = lane_rev;
`endif
         if (rev) begin
            q.push_back(in3); q.push_back(in2); q.push_back(in1); q.push_back(in0);
         end else begin
            q.push_back(in0); q.push_back(in1); q.push_back(in2); q.push_back(in3);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic [W-1:0] d, output int waited);
      in0 = a; in1 = b; in2 = c; in3 = d;
      in_valid = 1'b1;
      waited = 0;
      acc = 1'b0;
      while (!acc && waited < 50) begin
         tick();
         waited++;
      end
      if (!acc) chk("accept_timeout", waited, 0);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      while ((q.size() != 0) && n < 100) begin
         tick();
         n++;
      end
      chk("drain_left", q.size(), 0);
      tick();
   endtask

   initial begin
      int w;
      int acc0;

      // Reset state
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Single word, free-running sink: first byte one clock after capture
      out_ready = 1'b1;
      send_word(8'h11, 8'h22, 8'h33, 8'h44, w);
      chk("lat_valid", {31'd0, out_valid}, 32'd1);
      chk("lat_first", {24'd0, out_data}, 32'h11);
      repeat (6) tick();
      chk("idle_valid", {31'd0, out_valid}, 32'd0);

      // Back-to-back words: second accepted exactly 4 clocks later, no bubble
      send_word(8'h11, 8'h22, 8'h33, 8'h44, w);
      send_word(8'h55, 8'h66, 8'h77, 8'h88, w);
      chk("b2b_wait", w, 4);
      drain();

      // Stall with 22 on the output
      send_word(8'h11, 8'h22, 8'h33, 8'h44, w);
      tick();
      out_ready = 1'b0;
      repeat (3) tick();
      chk("stall_hold", {24'd0, out_data}, 32'h22);
      drain();

      // Held in_valid while not ready: captured exactly once
      out_ready = 1'b1;
      send_word(8'hA1, 8'hA2, 8'hA3, 8'hA4, w);
      out_ready = 1'b0;
      in0 = 8'hB1; in1 = 8'hB2; in2 = 8'hB3; in3 = 8'hB4;
      in_valid = 1'b1;
      acc0 = acc_cnt;
      repeat (5) tick();
      chk("hold_no_cap", acc_cnt - acc0, 0);
      out_ready = 1'b1;
      w = 0;
      while (acc_cnt == acc0 && w < 20) begin tick(); w++; end
      in_valid = 1'b0;
      chk("hold_cap_once", acc_cnt - acc0, 1);
      drain();

      // Reset asserted mid-word
      send_word(8'h11, 8'h22, 8'h33, 8'h44, w);
      tick();
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_data", {24'd0, out_data}, 32'd0);
      q.delete();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      tick();

`ifdef LANE_REVERSE_EN
      // Reverse order sampled at capture, immune to later toggling
      lane_rev = 1'b1;
      send_word(8'h11, 8'h22, 8'h33, 8'h44, w);
      lane_rev = 1'b0;
      chk("rev_first", {24'd0, out_data}, 32'h44);
      tick();
      lane_rev = 1'b1;
      tick();
      chk("rev_third", {24'd0, out_data}, 32'h22);
      drain();
`endif

      // Randomized traffic with random backpressure
      for (int i = 0; i < 2000; i++) begin
         if (!in_valid && ($urandom_range(0, 2) != 0)) begin
            in0 = W'($urandom); in1 = W'($urandom);
            in2 = W'($urandom); in3 = W'($urandom);
            in_valid = 1'b1;
         end
`ifdef LANE_REVERSE_EN
         lane_rev = 1'($urandom);
`endif
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
         if (acc) in_valid = 1'b0;
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
